vec_issue_ctrl: RTL and testbench

Sequencing controller between the vector decoder and the vector execution/load-store datapath. It accepts one decoded vector instruction at a time over a valid/ready handshake and owns the architectural vl and vtype registers. It executes vsetvli/vsetivli/vsetvl itself and splits register-group instructions into LMUL per-register micro-ops. While busy it stalls the scalar core.

---
 rtl/vec_issue_ctrl_pkg.sv | 35 +++
 rtl/vec_issue_ctrl_if.sv | 54 +++++
 rtl/vec_issue_ctrl_vlmax.sv | 27 ++
 rtl/vec_issue_ctrl.sv | 143 ++++++++++++++
 tb/tb_vec_issue_ctrl.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/vec_issue_ctrl_pkg.sv
// Shared definitions for the vector issue controller: geometry, state encoding,
// vtype field enums and the vill bit position.
package vec_issue_ctrl_pkg;

  localparam int XLEN_DEF = 32;
  localparam int VLEN     = 512;
  localparam int VL_W_DEF = $clog2(VLEN/8) + 4;
  localparam int VILL_BIT = XLEN_DEF - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CFG   = 2'd1,
    ISSUE = 2'd2,
    RESP  = 2'd3
  } issue_state_e;

  typedef enum logic [2:0] {
    LMUL_1 = 3'b000,
    LMUL_2 = 3'b001,
    LMUL_4 = 3'b010,
    LMUL_8 = 3'b011
  } vlmul_e;

  typedef enum logic [2:0] {
    SEW_8  = 3'b000,
    SEW_16 = 3'b001,
    SEW_32 = 3'b010
  } vsew_e;

  // Register-group size for an integral vlmul encoding.
  function automatic logic [3:0] lmul_count(input logic [1:0] vlmul);
    return 4'd1 << vlmul;
  endfunction

endpackage

// File: rtl/vec_issue_ctrl_if.sv
// Decoder-side instruction handshake plus datapath-side micro-op handshake.
// slave = controller view, master = surrounding decoder/datapath view.
interface vec_issue_ctrl_if #(
  parameter int XLEN = 32,
  parameter int VL_W = 10
);
  logic            inst_valid;
  logic            inst_ready;
  logic            is_config;
  logic            is_mask_op;
  logic            vec_op_valid;
  logic [4:0]      vd_addr;
  logic [4:0]      vs1_addr;
  logic [4:0]      vs2_addr;
  logic [5:0]      vfunc6;
  logic [XLEN-1:0] scalar1;
  logic [XLEN-1:0] scalar2;
  logic            rs1_is_x0;
  logic            rd_is_x0;
  logic [VL_W-1:0] vl;
  logic [XLEN-1:0] vtype;
  logic            rd_we;
  logic [XLEN-1:0] rd_wdata;
  logic            uop_valid;
  logic            uop_ready;
  logic [4:0]      uop_vd;
  logic [4:0]      uop_vs1;
  logic [4:0]      uop_vs2;
  logic [5:0]      uop_func6;
  logic [2:0]      uop_idx;
  logic            uop_last;
  logic            illegal_inst;
  logic            inst_done;
  logic            stall;

  modport master (
    output inst_valid, is_config, is_mask_op, vec_op_valid,
           vd_addr, vs1_addr, vs2_addr, vfunc6, scalar1, scalar2,
           rs1_is_x0, rd_is_x0, uop_ready,
    input  inst_ready, vl, vtype, rd_we, rd_wdata, uop_valid,
           uop_vd, uop_vs1, uop_vs2, uop_func6, uop_idx, uop_last,
           illegal_inst, inst_done, stall
  );

  modport slave (
    input  inst_valid, is_config, is_mask_op, vec_op_valid,
           vd_addr, vs1_addr, vs2_addr, vfunc6, scalar1, scalar2,
           rs1_is_x0, rd_is_x0, uop_ready,
    output inst_ready, vl, vtype, rd_we, rd_wdata, uop_valid,
           uop_vd, uop_vs1, uop_vs2, uop_func6, uop_idx, uop_last,
           illegal_inst, inst_done, stall
  );

endinterface

// File: rtl/vec_issue_ctrl_vlmax.sv
// Combinational vtype legality check and VLMAX for integral LMUL, SEW 8..32.
module vec_vlmax_calc
  import vec_issue_ctrl_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int VLEN = 512,
  parameter int VL_W = $clog2(VLEN/8) + 4
) (
  input  logic [XLEN-1:0] vtype,
  output logic [VL_W-1:0] vlmax,
  output logic            vill
);

  localparam logic [VL_W-1:0] BYTES_PER_REG = VL_W'(VLEN/8);

  logic [2:0] vlmul;
  logic [2:0] vsew;

  assign vlmul = vtype[2:0];
  assign vsew  = vtype[5:3];

  // Fractional LMUL, SEW64+ and any reserved/vill bit make the vtype illegal.
  assign vill  = vlmul[2] || (vsew > SEW_32) || (|vtype[XLEN-1:8]);

  assign vlmax = vill ? '0 : ((BYTES_PER_REG >> vsew) << vlmul[1:0]);

endmodule

// File: rtl/vec_issue_ctrl.sv
// Vector issue sequencer: owns vl/vtype, retires vset* itself and cracks
// register-group instructions into per-register micro-ops.
module vec_issue_ctrl
  import vec_issue_ctrl_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int VLEN = 512,
  parameter int VL_W = $clog2(VLEN/8) + 4
) (
  input logic          clk,
  input logic          reset,
  vec_issue_ctrl_if.slave bus
);

  localparam logic [XLEN-1:0] VTYPE_VILL = {1'b1, {(XLEN-1){1'b0}}};

  issue_state_e    state;
  logic [VL_W-1:0] vl_q;
  logic [XLEN-1:0] vtype_q;
  logic [2:0]      last_idx;

  logic [VL_W-1:0] new_vlmax;
  logic            new_vill;
  logic [VL_W-1:0] cfg_vl;
  logic [XLEN-1:0] cfg_vtype;
  logic [3:0]      grp_sz;
  logic [2:0]      grp_mask;
  logic            misaligned;
  logic            cur_vill;

  vec_vlmax_calc #(
    .XLEN (XLEN),
    .VLEN (VLEN),
    .VL_W (VL_W)
  ) u_vlmax (
    .vtype (bus.scalar2),
    .vlmax (new_vlmax),
    .vill  (new_vill)
  );

  assign bus.inst_ready = (state == IDLE);
  assign bus.stall      = bus.inst_valid && !bus.inst_ready;
  assign bus.vl         = vl_q;
  assign bus.vtype      = vtype_q;

  // Group checks use the current vtype; a vill vtype is rejected before these matter.
  assign cur_vill   = vtype_q[XLEN-1];
  assign grp_sz     = lmul_count(vtype_q[1:0]);
  assign grp_mask   = 3'(grp_sz - 4'd1);
  assign misaligned = |((bus.vd_addr[2:0] | bus.vs1_addr[2:0] | bus.vs2_addr[2:0]) & grp_mask);

  // AVL compare is done at full XLEN so large AVLs clamp instead of wrapping.
  always_comb begin
    cfg_vl    = vl_q;
    cfg_vtype = bus.scalar2;
    if (new_vill) begin
      cfg_vl    = '0;
      cfg_vtype = VTYPE_VILL;
    end else if (bus.rs1_is_x0 && !bus.rd_is_x0) begin
      cfg_vl = new_vlmax;
    end else if (bus.rs1_is_x0) begin
      cfg_vl = vl_q;
    end else if (bus.scalar1 < XLEN'(new_vlmax)) begin
      cfg_vl = VL_W'(bus.scalar1);
    end else begin
      cfg_vl = new_vlmax;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      vl_q             <= '0;
      vtype_q          <= VTYPE_VILL;
      last_idx         <= '0;
      bus.rd_we        <= 1'b0;
      bus.rd_wdata     <= '0;
      bus.uop_valid    <= 1'b0;
      bus.uop_vd       <= '0;
      bus.uop_vs1      <= '0;
      bus.uop_vs2      <= '0;
      bus.uop_func6    <= '0;
      bus.uop_idx      <= '0;
      bus.uop_last     <= 1'b0;
      bus.illegal_inst <= 1'b0;
      bus.inst_done    <= 1'b0;
    end else begin
      bus.rd_we        <= 1'b0;
      bus.illegal_inst <= 1'b0;
      bus.inst_done    <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.inst_valid) begin
            if (bus.is_config) begin
              vl_q         <= cfg_vl;
              vtype_q      <= cfg_vtype;
              bus.rd_we    <= 1'b1;
              bus.rd_wdata <= XLEN'(cfg_vl);
              bus.inst_done <= 1'b1;
              state        <= CFG;
            end else if (cur_vill || !bus.vec_op_valid ||
                         (!bus.is_mask_op && misaligned)) begin
              bus.illegal_inst <= 1'b1;
              state            <= RESP;
            end else if (vl_q == '0) begin
              bus.inst_done <= 1'b1;
              state         <= RESP;
            end else begin
              last_idx      <= bus.is_mask_op ? 3'd0 : 3'(grp_sz - 4'd1);
              bus.uop_valid <= 1'b1;
              bus.uop_vd    <= bus.vd_addr;
              bus.uop_vs1   <= bus.vs1_addr;
              bus.uop_vs2   <= bus.vs2_addr;
              bus.uop_func6 <= bus.vfunc6;
              bus.uop_idx   <= 3'd0;
              bus.uop_last  <= bus.is_mask_op || (grp_sz == 4'd1);
              state         <= ISSUE;
            end
          end
        end
        CFG, RESP: state <= IDLE;
        ISSUE: begin
          // Everything stays put until the datapath takes the current uop.
          if (bus.uop_ready) begin
            if (bus.uop_last) begin
              bus.uop_valid <= 1'b0;
              bus.inst_done <= 1'b1;
              state         <= IDLE;
            end else begin
              bus.uop_vd   <= bus.uop_vd + 5'd1;
              bus.uop_vs1  <= bus.uop_vs1 + 5'd1;
              bus.uop_vs2  <= bus.uop_vs2 + 5'd1;
              bus.uop_idx  <= bus.uop_idx + 3'd1;
              bus.uop_last <= ((bus.uop_idx + 3'd1) == last_idx);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vec_issue_ctrl.sv
// Directed bench for vec_issue_ctrl: vset* vl rules, uop cracking with
// backpressure, illegal/empty instructions and reset abort.
module tb_vec_issue_ctrl;
  import vec_issue_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;

  vec_issue_ctrl_if #(.XLEN(32), .VL_W(10)) bus ();

  vec_issue_ctrl #(.XLEN(32), .VLEN(512), .VL_W(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a vset* for one cycle; returns in the retire cycle.
  task automatic drive_cfg(input logic [31:0] avl, input logic [31:0] vt,
                           input logic rs1x0, input logic rdx0);
    bus.inst_valid = 1'b1;
    bus.is_config  = 1'b1;
    bus.scalar1    = avl;
    bus.scalar2    = vt;
    bus.rs1_is_x0  = rs1x0;
    bus.rd_is_x0   = rdx0;
    step();
    bus.inst_valid = 1'b0;
    bus.is_config  = 1'b0;
  endtask

  // Present a vector op for one cycle; returns in the cycle after acceptance.
  task automatic drive_vec(input logic [4:0] vd, input logic [4:0] vs1,
                           input logic [4:0] vs2, input logic mask,
                           input logic opv);
    bus.inst_valid   = 1'b1;
    bus.is_config    = 1'b0;
    bus.is_mask_op   = mask;
    bus.vec_op_valid = opv;
    bus.vd_addr      = vd;
    bus.vs1_addr     = vs1;
    bus.vs2_addr     = vs2;
    bus.vfunc6       = 6'h00;
    step();
    bus.inst_valid = 1'b0;
  endtask

  task automatic test_reset();
    bus.inst_valid = 0; bus.is_config = 0; bus.is_mask_op = 0; bus.vec_op_valid = 1;
    bus.vd_addr = 0; bus.vs1_addr = 0; bus.vs2_addr = 0; bus.vfunc6 = 0;
    bus.scalar1 = 0; bus.scalar2 = 0; bus.rs1_is_x0 = 0; bus.rd_is_x0 = 0;
    bus.uop_ready = 0;
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    total_cnt++; if (bus.vl !== 10'd0) $display("FAIL reset_vl got %0d exp 0", bus.vl); else pass_cnt++;
    total_cnt++; if (bus.vtype !== 32'h8000_0000) $display("FAIL reset_vtype got %h exp 80000000", bus.vtype); else pass_cnt++;
    total_cnt++; if (bus.inst_ready !== 1'b1) $display("FAIL reset_ready got %b exp 1", bus.inst_ready); else pass_cnt++;
    total_cnt++; if (bus.uop_valid !== 1'b0) $display("FAIL reset_uop_valid got %b exp 0", bus.uop_valid); else pass_cnt++;
  endtask

  task automatic test_cfg_basic();
    drive_cfg(32'd100, 32'h11, 1'b0, 1'b0);
    total_cnt++; if (bus.vl !== 10'd32) $display("FAIL cfg_avl100_vl got %0d exp 32", bus.vl); else pass_cnt++;
    total_cnt++; if (bus.rd_we !== 1'b1 || bus.rd_wdata !== 32'd32) $display("FAIL cfg_avl100_rd got we=%b d=%0d exp we=1 d=32", bus.rd_we, bus.rd_wdata); else pass_cnt++;
    total_cnt++; if (bus.inst_done !== 1'b1 || bus.inst_ready !== 1'b0) $display("FAIL cfg_avl100_done got done=%b rdy=%b exp done=1 rdy=0", bus.inst_done, bus.inst_ready); else pass_cnt++;
    total_cnt++; if (bus.vtype !== 32'h11) $display("FAIL cfg_avl100_vtype got %h exp 11", bus.vtype); else pass_cnt++;
    step();
    total_cnt++; if (bus.rd_we !== 1'b0 || bus.inst_done !== 1'b0 || bus.inst_ready !== 1'b1) $display("FAIL cfg_pulse_end got we=%b done=%b rdy=%b exp 0 0 1", bus.rd_we, bus.inst_done, bus.inst_ready); else pass_cnt++;
    drive_cfg(32'd10, 32'h11, 1'b0, 1'b0);
    total_cnt++; if (bus.vl !== 10'd10 || bus.rd_wdata !== 32'd10) $display("FAIL cfg_avl10 got vl=%0d d=%0d exp 10 10", bus.vl, bus.rd_wdata); else pass_cnt++;
    step();
  endtask

  task automatic test_cfg_vlmax();
    drive_cfg(32'd7, 32'h03, 1'b1, 1'b0);
    total_cnt++; if (bus.vl !== 10'd512 || bus.rd_wdata !== 32'd512) $display("FAIL cfg_vlmax got vl=%0d d=%0d exp 512 512", bus.vl, bus.rd_wdata); else pass_cnt++;
    step();
    drive_cfg(32'd7, 32'h11, 1'b1, 1'b1);
    total_cnt++; if (bus.vl !== 10'd512 || bus.vtype !== 32'h11) $display("FAIL cfg_keep_vl got vl=%0d vt=%h exp 512 11", bus.vl, bus.vtype); else pass_cnt++;
    step();
    // AVL of 1024 would read as 0 if compared at vl width.
    drive_cfg(32'h400, 32'h11, 1'b0, 1'b0);
    total_cnt++; if (bus.vl !== 10'd32) $display("FAIL cfg_clamp_wide got %0d exp 32", bus.vl); else pass_cnt++;
    step();
    drive_cfg(32'd32, 32'h11, 1'b0, 1'b0);
    total_cnt++; if (bus.vl !== 10'd32) $display("FAIL cfg_avl_eq_vlmax got %0d exp 32", bus.vl); else pass_cnt++;
    step();
    drive_cfg(32'd10, 32'h11, 1'b0, 1'b0);
    step();
  endtask

  task automatic test_back_pressure();
    bus.inst_valid = 1; bus.is_config = 0; bus.is_mask_op = 0; bus.vec_op_valid = 1;
    bus.vd_addr = 5'd4; bus.vs2_addr = 5'd8; bus.vs1_addr = 5'd12; bus.vfunc6 = 6'h00;
    bus.uop_ready = 0;
    step();
    total_cnt++; if (bus.stall !== 1'b1 || bus.inst_ready !== 1'b0) $display("FAIL issue_stall got stall=%b rdy=%b exp 1 0", bus.stall, bus.inst_ready); else pass_cnt++;
    for (int c = 0; c < 4; c++) begin
      total_cnt++;
      if (bus.uop_valid !== 1'b1 || bus.uop_vd !== 5'd4 || bus.uop_vs2 !== 5'd8 ||
          bus.uop_vs1 !== 5'd12 || bus.uop_idx !== 3'd0 || bus.uop_last !== 1'b0)
        $display("FAIL uop0_hold_c%0d got v=%b vd=%0d vs2=%0d vs1=%0d idx=%0d last=%b exp 1 4 8 12 0 0",
                 c, bus.uop_valid, bus.uop_vd, bus.uop_vs2, bus.uop_vs1, bus.uop_idx, bus.uop_last);
      else pass_cnt++;
      if (c == 2) bus.inst_valid = 0;
      if (c == 3) bus.uop_ready = 1;
      else step();
    end
    step();
    total_cnt++;
    if (bus.uop_valid !== 1'b1 || bus.uop_vd !== 5'd5 || bus.uop_vs2 !== 5'd9 ||
        bus.uop_vs1 !== 5'd13 || bus.uop_idx !== 3'd1 || bus.uop_last !== 1'b1)
      $display("FAIL uop1 got v=%b vd=%0d vs2=%0d vs1=%0d idx=%0d last=%b exp 1 5 9 13 1 1",
               bus.uop_valid, bus.uop_vd, bus.uop_vs2, bus.uop_vs1, bus.uop_idx, bus.uop_last);
    else pass_cnt++;
    total_cnt++; if (bus.inst_done !== 1'b0) $display("FAIL uop1_no_done got %b exp 0", bus.inst_done); else pass_cnt++;
    step();
    total_cnt++; if (bus.uop_valid !== 1'b0 || bus.inst_done !== 1'b1 || bus.inst_ready !== 1'b1) $display("FAIL issue_retire got v=%b done=%b rdy=%b exp 0 1 1", bus.uop_valid, bus.inst_done, bus.inst_ready); else pass_cnt++;
    bus.uop_ready = 0;
    step();
  endtask

  task automatic test_illegal();
    drive_vec(5'd3, 5'd12, 5'd8, 1'b0, 1'b1);
    total_cnt++; if (bus.illegal_inst !== 1'b1 || bus.uop_valid !== 1'b0 || bus.inst_done !== 1'b0) $display("FAIL misalign_vd got ill=%b v=%b done=%b exp 1 0 0", bus.illegal_inst, bus.uop_valid, bus.inst_done); else pass_cnt++;
    step();
    total_cnt++; if (bus.illegal_inst !== 1'b0 || bus.inst_ready !== 1'b1) $display("FAIL misalign_pulse got ill=%b rdy=%b exp 0 1", bus.illegal_inst, bus.inst_ready); else pass_cnt++;
    drive_vec(5'd4, 5'd5, 5'd8, 1'b0, 1'b1);
    total_cnt++; if (bus.illegal_inst !== 1'b1 || bus.uop_valid !== 1'b0) $display("FAIL misalign_vs1 got ill=%b v=%b exp 1 0", bus.illegal_inst, bus.uop_valid); else pass_cnt++;
    step();
    drive_vec(5'd4, 5'd12, 5'd8, 1'b0, 1'b0);
    total_cnt++; if (bus.illegal_inst !== 1'b1 || bus.uop_valid !== 1'b0) $display("FAIL bad_func6 got ill=%b v=%b exp 1 0", bus.illegal_inst, bus.uop_valid); else pass_cnt++;
    step();
  endtask

  task automatic test_mask_op();
    bus.uop_ready = 1;
    drive_vec(5'd3, 5'd5, 5'd7, 1'b1, 1'b1);
    total_cnt++;
    if (bus.uop_valid !== 1'b1 || bus.uop_vd !== 5'd3 || bus.uop_idx !== 3'd0 || bus.uop_last !== 1'b1 || bus.illegal_inst !== 1'b0)
      $display("FAIL mask_uop got v=%b vd=%0d idx=%0d last=%b ill=%b exp 1 3 0 1 0", bus.uop_valid, bus.uop_vd, bus.uop_idx, bus.uop_last, bus.illegal_inst);
    else pass_cnt++;
    step();
    total_cnt++; if (bus.uop_valid !== 1'b0 || bus.inst_done !== 1'b1) $display("FAIL mask_retire got v=%b done=%b exp 0 1", bus.uop_valid, bus.inst_done); else pass_cnt++;
    bus.uop_ready = 0;
    step();
  endtask

  task automatic test_vl_zero();
    drive_cfg(32'd0, 32'h11, 1'b0, 1'b0);
    total_cnt++; if (bus.vl !== 10'd0 || bus.rd_wdata !== 32'd0) $display("FAIL cfg_avl0 got vl=%0d d=%0d exp 0 0", bus.vl, bus.rd_wdata); else pass_cnt++;
    step();
    drive_vec(5'd4, 5'd12, 5'd8, 1'b0, 1'b1);
    total_cnt++; if (bus.inst_done !== 1'b1 || bus.illegal_inst !== 1'b0 || bus.uop_valid !== 1'b0) $display("FAIL vl0_vadd got done=%b ill=%b v=%b exp 1 0 0", bus.inst_done, bus.illegal_inst, bus.uop_valid); else pass_cnt++;
    step();
  endtask

  task automatic test_illegal_vtype();
    drive_cfg(32'd10, 32'h11, 1'b0, 1'b0);
    step();
    drive_cfg(32'd100, 32'h18, 1'b0, 1'b0);
    total_cnt++; if (bus.vl !== 10'd0 || bus.vtype !== 32'h8000_0000) $display("FAIL vill_cfg got vl=%0d vt=%h exp 0 80000000", bus.vl, bus.vtype); else pass_cnt++;
    step();
    drive_vec(5'd4, 5'd12, 5'd8, 1'b0, 1'b1);
    total_cnt++; if (bus.illegal_inst !== 1'b1 || bus.uop_valid !== 1'b0) $display("FAIL vill_vadd got ill=%b v=%b exp 1 0", bus.illegal_inst, bus.uop_valid); else pass_cnt++;
    step();
    drive_cfg(32'd100, 32'h05, 1'b0, 1'b0);
    total_cnt++; if (bus.vl !== 10'd0 || bus.vtype !== 32'h8000_0000) $display("FAIL frac_lmul got vl=%0d vt=%h exp 0 80000000", bus.vl, bus.vtype); else pass_cnt++;
    step();
  endtask

  task automatic test_reset_abort();
    drive_cfg(32'd10, 32'h11, 1'b0, 1'b0);
    step();
    bus.uop_ready = 0;
    drive_vec(5'd4, 5'd12, 5'd8, 1'b0, 1'b1);
    total_cnt++; if (bus.uop_valid !== 1'b1) $display("FAIL abort_issue got v=%b exp 1", bus.uop_valid); else pass_cnt++;
    reset = 1'b1;
    step();
    reset = 1'b0;
    total_cnt++; if (bus.uop_valid !== 1'b0 || bus.inst_done !== 1'b0 || bus.inst_ready !== 1'b1 || bus.vl !== 10'd0) $display("FAIL abort_reset got v=%b done=%b rdy=%b vl=%0d exp 0 0 1 0", bus.uop_valid, bus.inst_done, bus.inst_ready, bus.vl); else pass_cnt++;
    step();
    total_cnt++; if (bus.inst_done !== 1'b0) $display("FAIL abort_no_done got %b exp 0", bus.inst_done); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_cfg_basic();
    test_cfg_vlmax();
    test_back_pressure();
    test_illegal();
    test_mask_op();
    test_vl_zero();
    test_illegal_vtype();
    test_reset_abort();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
